// File: rtl/ddr3_app_sequencer.sv
// Single-beat request sequencer in front of the DDR3 controller user interface.
// Optional statistics counters are built when DDR3_SEQ_STATS_EN is defined.
module ddr3_app_sequencer #(
    parameter int ADDR_WIDTH      = 28,
    parameter int APP_DATA_WIDTH  = 64,
    parameter int APP_MASK_WIDTH  = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_calib_complete,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wr,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [APP_DATA_WIDTH-1:0] req_wdata,
    input  logic [APP_MASK_WIDTH-1:0] req_wmask,
    output logic                      rsp_valid,
    output logic [APP_DATA_WIDTH-1:0] rsp_data,
    output logic                      rd_unexp,
    input  logic                      cmd_ready,
    output logic                      cmd_en,
    output logic [2:0]                cmd,
    output logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      wr_data_rdy,
    output logic                      wr_data_en,
    output logic                      wr_data_end,
    output logic [APP_DATA_WIDTH-1:0] wr_data,
    output logic [APP_MASK_WIDTH-1:0] wr_data_mask,
    input  logic                      rd_data_valid,
    input  logic                      rd_data_end,
    input  logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      burst,
    output logic [31:0]               wr_count,
    output logic [31:0]               rd_count
);

    typedef enum logic [1:0] {WAIT_CALIB, IDLE, ISSUE} state_t;

    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    state_t                    state_q, state_d;
    logic                      wr_q;
    logic [2:0]                cmd_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [APP_DATA_WIDTH-1:0] wdata_q;
    logic [APP_MASK_WIDTH-1:0] wmask_q;
    logic [7:0]                out_q, out_d;
    logic                      unexp_q, unexp_d;
    logic                      rsp_valid_q;
    logic [APP_DATA_WIDTH-1:0] rsp_data_q;
    logic                      accept, fire, wr_fire, rd_fire, rd_ret;

    assign req_ready = (state_q == IDLE) & init_calib_complete &
                       (req_wr | (out_q < MAX_OUT));
    assign accept    = req_valid & req_ready;
    assign rd_ret    = rd_data_valid & rd_data_end;

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            WAIT_CALIB: if (init_calib_complete) state_d = IDLE;
            IDLE: begin
                if (!init_calib_complete) state_d = WAIT_CALIB;
                else if (accept)          state_d = ISSUE;
            end
            ISSUE: begin
                // A write needs both command and data slots in the same cycle.
                fire = wr_q ? (cmd_ready & wr_data_rdy) : cmd_ready;
                if (fire) state_d = IDLE;
            end
            default: state_d = WAIT_CALIB;
        endcase
    end

    assign wr_fire = fire & wr_q;
    assign rd_fire = fire & ~wr_q;

    always_comb begin
        out_d   = out_q;
        unexp_d = unexp_q;
        if (rd_fire && !rd_ret) begin
            out_d = out_q + 8'd1;
        end else if (rd_ret && !rd_fire) begin
            if (out_q == 8'd0) unexp_d = 1'b1;
            else               out_d   = out_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_CALIB;
            wr_q        <= 1'b0;
            cmd_q       <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            out_q       <= 8'd0;
            unexp_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            unexp_q     <= unexp_d;
            rsp_valid_q <= rd_data_valid;
            rsp_data_q  <= rd_data;
            if (accept) begin
                wr_q    <= req_wr;
                cmd_q   <= req_wr ? 3'b000 : 3'b001;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
            end
        end
    end

    assign cmd_en       = fire;
    assign cmd          = cmd_q;
    assign addr         = addr_q;
    assign wr_data_en   = wr_fire;
    assign wr_data_end  = wr_fire;
    assign wr_data      = wdata_q;
    assign wr_data_mask = wmask_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rd_unexp     = unexp_q;
    assign burst        = 1'b0;

`ifdef DDR3_SEQ_STATS_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= 32'd0;
            rd_cnt_q <= 32'd0;
        end else begin
            if (wr_fire && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (rd_fire && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`else
    assign wr_count = 32'd0;
    assign rd_count = 32'd0;
`endif

endmodule

// File: tb/tb_ddr3_app_sequencer.sv
// Directed and randomized checks of ddr3_app_sequencer against a cycle-level behavioural model.
module tb_ddr3_app_sequencer;
    localparam int AW = 28, DW = 64, MW = 8, MAXO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_calib_complete = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_wmask = '0;
    logic          rsp_valid, rd_unexp;
    logic [DW-1:0] rsp_data;
    logic          cmd_ready = 1'b0, cmd_en;
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic          wr_data_rdy = 1'b0, wr_data_en, wr_data_end;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_data_mask;
    logic          rd_data_valid = 1'b0, rd_data_end = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          burst;
    logic [31:0]   wr_count, rd_count;

    ddr3_app_sequencer #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
                         .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rd_unexp(rd_unexp),
        .cmd_ready(cmd_ready), .cmd_en(cmd_en), .cmd(cmd), .addr(addr),
        .wr_data_rdy(wr_data_rdy), .wr_data_en(wr_data_en), .wr_data_end(wr_data_end),
        .wr_data(wr_data), .wr_data_mask(wr_data_mask),
        .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end), .rd_data(rd_data),
        .burst(burst), .wr_count(wr_count), .rd_count(rd_count));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    // Model: mode 0 = waiting for calibration, 1 = ready for a request, 2 = holding a command.
    int            m_mode = 0, m_out = 0;
    bit            m_unexp = 0, p_wr = 0, last_rdv = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0, last_rdata = '0;
    logic [MW-1:0] p_mask = '0;
    int unsigned   m_wrc = 0, m_rdc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_wrc();
`ifdef DDR3_SEQ_STATS_EN
        return m_wrc;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_rdc();
`ifdef DDR3_SEQ_STATS_EN
        return m_rdc;
`else
        return 32'd0;
`endif
    endfunction

    task automatic cycle(input bit calib, input bit valid, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m, input bit cr,
                         input bit wdr, input bit rdv, input logic [DW-1:0] rdat);
        bit exp_ready, fire;
        @(negedge clk);
        init_calib_complete = calib; req_valid = valid; req_wr = wr; req_addr = a;
        req_wdata = d; req_wmask = m; cmd_ready = cr; wr_data_rdy = wdr;
        rd_data_valid = rdv; rd_data_end = rdv; rd_data = rdat;
        #1;
        exp_ready = (m_mode == 1) && calib && (wr || (m_out < MAXO));
        fire      = (m_mode == 2) && (p_wr ? (cr && wdr) : cr);
        chk("req_ready", req_ready, exp_ready);
        chk("cmd_en", cmd_en, fire);
        chk("wr_data_en", wr_data_en, fire && p_wr);
        chk("wr_data_end", wr_data_end, fire && p_wr);
        chk("burst", burst, 0);
        chk("rsp_valid", rsp_valid, last_rdv);
        if (last_rdv) chk("rsp_data", rsp_data, last_rdata);
        chk("rd_unexp", rd_unexp, m_unexp);
        chk("wr_count", wr_count, exp_wrc());
        chk("rd_count", rd_count, exp_rdc());
        if (m_mode == 2) begin
            chk("cmd", cmd, p_wr ? 3'b000 : 3'b001);
            chk("addr", addr, p_addr);
            if (p_wr) begin
                chk("wr_data", wr_data, p_data);
                chk("wr_mask", wr_data_mask, p_mask);
            end
        end
        // Advance the model across the coming rising edge.
        if (fire && !p_wr && !rdv) m_out++;
        else if (rdv && !(fire && !p_wr)) begin
            if (m_out == 0) m_unexp = 1;
            else m_out--;
        end
        if (fire) begin
            if (p_wr) m_wrc++;
            else m_rdc++;
        end
        case (m_mode)
            0: if (calib) m_mode = 1;
            1: if (!calib) m_mode = 0;
               else if (valid && exp_ready) begin
                   m_mode = 2; p_wr = wr; p_addr = a; p_data = d; p_mask = m;
               end
            default: if (fire) m_mode = 1;
        endcase
        last_rdv = rdv; last_rdata = rdat;
    endtask

    task automatic req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
        cycle(1, 1, wr, a, d, m, 0, 0, 0, '0);
    endtask

    task automatic go(input bit calib, input bit cr, input bit wdr, input bit rdv,
                      input logic [DW-1:0] rdat);
        cycle(calib, 0, 0, '0, '0, '0, cr, wdr, rdv, rdat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; init_calib_complete = 0; req_valid = 0; cmd_ready = 0;
        wr_data_rdy = 0; rd_data_valid = 0; rd_data_end = 0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_wr_data_en", wr_data_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rd_unexp", rd_unexp, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);
        m_mode = 0; m_out = 0; m_unexp = 0; last_rdv = 0; m_wrc = 0; m_rdc = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        // Reset and calibration gating.
        do_reset();
        cycle(0, 1, 0, 28'h20, '0, '0, 1, 1, 0, '0);
        chk("precal_ready", req_ready, 0);
        chk("precal_cmd_en", cmd_en, 0);
        cycle(1, 1, 0, 28'h20, '0, '0, 0, 0, 0, '0);
        req(0, 28'h20, '0, '0);
        chk("first_accept", req_ready, 1);
        go(1, 1, 0, 0, '0);
        chk("first_cmd_en", cmd_en, 1);
        go(1, 0, 0, 1, 64'h1111);
        go(1, 0, 0, 0, '0);

        // Write stalled on wr_data_rdy.
        req(1, 28'h1000, 64'hDEAD_BEEF_0123_4567, 8'h00);
        for (int i = 0; i < 3; i++) begin
            go(1, 1, 0, 0, '0);
            chk("wstall_cmd_en", cmd_en, 0);
            chk("wstall_wr_en", wr_data_en, 0);
        end
        go(1, 1, 1, 0, '0);
        chk("w_cmd", cmd, 3'b000);
        chk("w_addr", addr, 28'h1000);
        chk("w_en", wr_data_en, 1);
        chk("w_end", wr_data_end, 1);
        chk("w_data", wr_data, 64'hDEAD_BEEF_0123_4567);

        // Outstanding read bound.
        for (int i = 0; i < MAXO; i++) begin
            req(0, AW'(28'h200 + i), '0, '0);
            go(1, 1, 0, 0, '0);
        end
        req(0, 28'h300, '0, '0);
        chk("bound_full", req_ready, 0);
        cycle(1, 1, 0, 28'h300, '0, '0, 0, 0, 1, 64'hA0);
        req(0, 28'h300, '0, '0);
        chk("bound_after_ret", req_ready, 1);
        go(1, 1, 0, 1, 64'hA1);
        req(0, 28'h301, '0, '0);
        chk("same_cycle_unchanged", req_ready, 1);
        go(1, 1, 0, 0, '0);
        req(0, 28'h302, '0, '0);
        chk("bound_full_again", req_ready, 0);
        for (int i = 0; i < MAXO; i++) go(1, 0, 0, 1, 64'hB0 + 64'(i));

        // Unexpected read data.
        go(1, 0, 0, 1, 64'h55);
        go(1, 0, 0, 0, '0);
        chk("unexp_rsp_valid", rsp_valid, 1);
        chk("unexp_rsp_data", rsp_data, 64'h55);
        chk("unexp_flag", rd_unexp, 1);
        go(1, 0, 0, 0, '0);
        go(1, 0, 0, 0, '0);
        chk("unexp_sticky", rd_unexp, 1);

        // Calibration drop while a read is stalled.
        req(0, 28'h400, '0, '0);
        go(0, 0, 0, 0, '0);
        go(0, 0, 0, 0, '0);
        go(0, 1, 0, 0, '0);
        chk("drop_fire", cmd_en, 1);
        cycle(0, 1, 0, 28'h401, '0, '0, 1, 1, 0, '0);
        chk("drop_ready", req_ready, 0);
        cycle(1, 1, 0, 28'h401, '0, '0, 1, 1, 0, '0);
        chk("drop_wait", req_ready, 0);
        go(1, 0, 0, 1, 64'h77);

        // Statistics: 3 writes then 2 reads from reset.
        do_reset();
        go(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            req(1, AW'(28'h500 + i), 64'(i), 8'h0F);
            go(1, 1, 1, 0, '0);
        end
        for (int i = 0; i < 2; i++) begin
            req(0, AW'(28'h600 + i), '0, '0);
            go(1, 1, 0, 0, '0);
        end
        go(1, 0, 0, 1, 64'hC0);
        go(1, 0, 0, 1, 64'hC1);
`ifdef DDR3_SEQ_STATS_EN
        chk("stats_wr", wr_count, 32'd3);
        chk("stats_rd", rd_count, 32'd2);
`else
        chk("stats_wr", wr_count, 32'd0);
        chk("stats_rd", rd_count, 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit rv;
            rv = (m_out > 0) ? ($urandom_range(2) == 0) : ($urandom_range(60) == 0);
            cycle($urandom_range(19) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                  AW'($urandom), {$urandom, $urandom}, MW'($urandom),
                  $urandom_range(3) != 0, $urandom_range(3) != 0, rv, {$urandom, $urandom});
        end

        // Reset while a read is pending; a late beat is then unexpected.
        do_reset();
        go(1, 0, 0, 0, '0);
        req(0, 28'h700, '0, '0);
        go(1, 0, 0, 0, '0);
        do_reset();
        go(1, 0, 0, 1, 64'h99);
        go(1, 0, 0, 0, '0);
        chk("late_beat_unexp", rd_unexp, 1);
        chk("late_beat_data", rsp_data, 64'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
